clb_multi: RTL and testbench

- Next-generation configurable logic block: NUM_LUTS LUTs per block, each with its own serially configured input muxes, truth table and output mode (combinational or registered).
- Configured by a bit-serial frame. Once its frame is consumed, the block forwards further config bits to the next block, forming a daisy chain.
- Sits in the fabric array between the neighbour/IO routing and the run-time outputs.

---
 rtl/clb_multi.sv | 209 ++++++++++++++++++++
 tb/tb_clb_multi.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clb_multi.sv
// Configurable logic block with NUM_LUTS bit-serially configured LUTs and a config daisy-chain port.
// Each LUT input selects a neighbour, IO, feedback FF or constant; outputs are combinational or registered.
module clb_multi #(
  parameter int NUM_NEIGHBOUR_SIGNALS = 8,
  parameter int NUM_IO_SIGNALS        = 4,
  parameter int LUT_WIDTH             = 4,
  parameter int NUM_LUTS              = 2,
  parameter int IDX_BITS              = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_start,
  input  logic                             cfg_valid,
  input  logic                             cfg_data,
  output logic                             cfg_start_out,
  output logic                             cfg_valid_out,
  output logic                             cfg_data_out,
  output logic                             cfg_done,
  input  logic                             run,
  input  logic [NUM_NEIGHBOUR_SIGNALS-1:0] run_in_neighbours,
  input  logic [NUM_IO_SIGNALS-1:0]        run_in_io,
  output logic [NUM_LUTS-1:0]              run_out
);

  localparam int TT_SIZE = 1 << LUT_WIDTH;
  localparam int CNT_MAX = (IDX_BITS > TT_SIZE) ? IDX_BITS : TT_SIZE;
  localparam int BIT_W   = $clog2(CNT_MAX);
  localparam int LUT_W   = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;
  localparam int INP_W   = (LUT_WIDTH > 1) ? $clog2(LUT_WIDTH) : 1;
  localparam int NB_W    = (NUM_NEIGHBOUR_SIGNALS > 1) ? $clog2(NUM_NEIGHBOUR_SIGNALS) : 1;
  localparam int IO_W    = (NUM_IO_SIGNALS > 1) ? $clog2(NUM_IO_SIGNALS) : 1;
  localparam int FB_W    = LUT_W;

  typedef enum logic [2:0] {
    UNCONFIGURED,
    LOAD_TYPE,
    LOAD_INDEX,
    LOAD_TT,
    LOAD_MODE,
    CONFIGURED
  } state_t;

  state_t             state_q, state_d;
  logic [LUT_W-1:0]   lut_q, lut_d;
  logic [INP_W-1:0]   inp_q, inp_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               done_q, done_d;

  logic [NUM_LUTS-1:0][LUT_WIDTH-1:0][1:0]          type_q;
  logic [NUM_LUTS-1:0][LUT_WIDTH-1:0][IDX_BITS-1:0] idx_q;
  logic [NUM_LUTS-1:0][TT_SIZE-1:0]                 tt_q;
  logic [NUM_LUTS-1:0]                              mode_q;
  logic [NUM_LUTS-1:0]                              ff_q;
  logic                                             start_out_q, valid_out_q, data_out_q;

  logic [NUM_LUTS-1:0][LUT_WIDTH-1:0] lut_in;
  logic [NUM_LUTS-1:0]                lut_comb;
  logic                               accept;

  // a start pulse always wins over a coincident data bit
  assign accept = cfg_valid & ~cfg_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= UNCONFIGURED;
      lut_q   <= '0;
      inp_q   <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lut_q   <= lut_d;
      inp_q   <= inp_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lut_d   = lut_q;
    inp_d   = inp_q;
    bit_d   = bit_q;
    done_d  = done_q;
    if (cfg_start) begin
      state_d = LOAD_TYPE;
      lut_d   = '0;
      inp_d   = '0;
      bit_d   = '0;
      done_d  = 1'b0;
    end else if (cfg_valid) begin
      case (state_q)
        LOAD_TYPE: begin
          if (bit_q == BIT_W'(1)) begin
            bit_d   = '0;
            state_d = LOAD_INDEX;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
        LOAD_INDEX: begin
          if (bit_q == BIT_W'(IDX_BITS - 1)) begin
            bit_d = '0;
            if (inp_q == INP_W'(LUT_WIDTH - 1)) begin
              inp_d   = '0;
              state_d = LOAD_TT;
            end else begin
              inp_d   = inp_q + 1'b1;
              state_d = LOAD_TYPE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
        LOAD_TT: begin
          if (bit_q == BIT_W'(TT_SIZE - 1)) begin
            bit_d   = '0;
            state_d = LOAD_MODE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
        LOAD_MODE: begin
          if (lut_q == LUT_W'(NUM_LUTS - 1)) begin
            lut_d   = '0;
            state_d = CONFIGURED;
            done_d  = 1'b1;
          end else begin
            lut_d   = lut_q + 1'b1;
            state_d = LOAD_TYPE;
          end
        end
        default: ;
      endcase
    end
  end

  // fields shift in MSB-first; the first truth-table bit ends up in the top entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      type_q <= '0;
      idx_q  <= '0;
      tt_q   <= '0;
      mode_q <= '0;
    end else if (accept) begin
      case (state_q)
        LOAD_TYPE:  type_q[lut_q][inp_q] <= {type_q[lut_q][inp_q][0], cfg_data};
        LOAD_INDEX: idx_q[lut_q][inp_q]  <= {idx_q[lut_q][inp_q][IDX_BITS-2:0], cfg_data};
        LOAD_TT:    tt_q[lut_q]          <= {tt_q[lut_q][TT_SIZE-2:0], cfg_data};
        LOAD_MODE:  mode_q[lut_q]        <= cfg_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_out_q <= 1'b0;
      valid_out_q <= 1'b0;
      data_out_q  <= 1'b0;
    end else begin
      start_out_q <= cfg_start;
      valid_out_q <= (state_q == CONFIGURED) && accept;
      data_out_q  <= (state_q == CONFIGURED) && accept && cfg_data;
    end
  end

  // feedback reads only the output FFs, so no combinational loop can form
  always_comb begin
    lut_in = '0;
    for (int k = 0; k < NUM_LUTS; k++) begin
      for (int i = 0; i < LUT_WIDTH; i++) begin
        case (type_q[k][i])
          2'd0: lut_in[k][i] = (int'(idx_q[k][i]) < NUM_NEIGHBOUR_SIGNALS) ?
                               run_in_neighbours[idx_q[k][i][NB_W-1:0]] : 1'b0;
          2'd1: lut_in[k][i] = (int'(idx_q[k][i]) < NUM_IO_SIGNALS) ?
                               run_in_io[idx_q[k][i][IO_W-1:0]] : 1'b0;
          2'd2: lut_in[k][i] = (int'(idx_q[k][i]) < NUM_LUTS) ?
                               ff_q[idx_q[k][i][FB_W-1:0]] : 1'b0;
          default: lut_in[k][i] = idx_q[k][i][0];
        endcase
      end
    end
  end

  always_comb begin
    lut_comb = '0;
    for (int k = 0; k < NUM_LUTS; k++) begin
      lut_comb[k] = tt_q[k][lut_in[k]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_q <= '0;
    end else if (cfg_start) begin
      ff_q <= '0;
    end else if (run && done_q) begin
      ff_q <= lut_comb;
    end
  end

  assign run_out       = (mode_q & ff_q) | (~mode_q & {NUM_LUTS{done_q}} & lut_comb);
  assign cfg_done      = done_q;
  assign cfg_start_out = start_out_q;
  assign cfg_valid_out = valid_out_q;
  assign cfg_data_out  = data_out_q;

endmodule

// File: tb/tb_clb_multi.sv
// Directed bench for clb_multi: frames are built from per-LUT field records and
// driven serially; outputs are compared against hand-derived expectations.
module tb_clb_multi;

  localparam int FRAME = 114;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start, cfg_valid, cfg_data;
  logic       cfg_start_out, cfg_valid_out, cfg_data_out, cfg_done;
  logic       run;
  logic [7:0] run_in_neighbours;
  logic [3:0] run_in_io;
  logic [1:0] run_out;

  int n_checks = 0;
  int n_fail   = 0;

  clb_multi dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_start         (cfg_start),
    .cfg_valid         (cfg_valid),
    .cfg_data          (cfg_data),
    .cfg_start_out     (cfg_start_out),
    .cfg_valid_out     (cfg_valid_out),
    .cfg_data_out      (cfg_data_out),
    .cfg_done          (cfg_done),
    .run               (run),
    .run_in_neighbours (run_in_neighbours),
    .run_in_io         (run_in_io),
    .run_out           (run_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][1:0] typ;
    logic [3:0][7:0] idx;
    logic [15:0]     tt;
    logic            mode;
  } lut_cfg_t;

  typedef struct {
    logic [7:0] nb;
    logic [3:0] io;
    logic [1:0] exp_out;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FRAME-1:0] build_frame(input lut_cfg_t l0, input lut_cfg_t l1);
    logic [FRAME-1:0] f;
    lut_cfg_t         c;
    int               pos;
    f   = '0;
    pos = FRAME - 1;
    for (int k = 0; k < 2; k++) begin
      c = (k == 0) ? l0 : l1;
      for (int i = 0; i < 4; i++) begin
        for (int b = 1; b >= 0; b--) begin f[pos] = c.typ[i][b]; pos--; end
        for (int b = 7; b >= 0; b--) begin f[pos] = c.idx[i][b]; pos--; end
      end
      for (int b = 15; b >= 0; b--) begin f[pos] = c.tt[b]; pos--; end
      f[pos] = c.mode;
      pos--;
    end
    return f;
  endfunction

  task automatic do_start();
    cfg_start = 1'b1;
    cfg_valid = 1'b0;
    tick();
    check("start_out_after_start", cfg_start_out, 1);
    cfg_start = 1'b0;
    tick();
    check("start_out_drops", cfg_start_out, 0);
  endtask

  // gap_at: frame bit index before which cfg_valid is held low for 3 cycles (-1 = none)
  task automatic send_frame(input logic [FRAME-1:0] f, input int gap_at, output int fwd_pulses);
    fwd_pulses = 0;
    for (int i = FRAME - 1; i >= 0; i--) begin
      if (i == gap_at) begin
        cfg_valid = 1'b0;
        repeat (3) begin
          tick();
          if (cfg_valid_out) fwd_pulses++;
        end
      end
      cfg_valid = 1'b1;
      cfg_data  = f[i];
      tick();
      if (cfg_valid_out) fwd_pulses++;
      if (i == 1) check("done_low_before_last_bit", cfg_done, 0);
    end
    cfg_valid = 1'b0;
    cfg_data  = 1'b0;
  endtask

  lut_cfg_t         a0, a1, b0, b1;
  logic [FRAME-1:0] frame_a, frame_b;
  vec_t             vecs [6];
  int               pulses;
  logic [4:0]       extra;
  logic [1:0]       toggle_exp [5];

  initial begin
    rst = 1'b1;
    cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = 1'b0;
    run = 1'b0; run_in_neighbours = '0; run_in_io = '0;

    // LUT0: AND of neighbours 0..3, combinational
    a0.typ = '0;
    a0.idx = {8'd3, 8'd2, 8'd1, 8'd0};
    a0.tt = 16'h8000; a0.mode = 1'b0;
    // LUT1: registered, in0 = feedback of LUT1, truth table NOT in0
    a1.typ = {2'd3, 2'd3, 2'd3, 2'd2};
    a1.idx = {8'd0, 8'd0, 8'd0, 8'd1};
    a1.tt = 16'h5555; a1.mode = 1'b1;
    // LUT0: buffer of io[7] (out of range); LUT1: buffer of constant 1
    b0.typ = {2'd3, 2'd3, 2'd3, 2'd1};
    b0.idx = {8'd0, 8'd0, 8'd0, 8'd7};
    b0.tt = 16'hAAAA; b0.mode = 1'b0;
    b1.typ = {2'd3, 2'd3, 2'd3, 2'd3};
    b1.idx = {8'd0, 8'd0, 8'd0, 8'd1};
    b1.tt = 16'hAAAA; b1.mode = 1'b0;
    frame_a = build_frame(a0, a1);
    frame_b = build_frame(b0, b1);

    vecs[0] = '{nb: 8'h0F, io: 4'h0, exp_out: 2'b01};
    vecs[1] = '{nb: 8'h0E, io: 4'h0, exp_out: 2'b00};
    vecs[2] = '{nb: 8'hFF, io: 4'hF, exp_out: 2'b01};
    vecs[3] = '{nb: 8'hF0, io: 4'hF, exp_out: 2'b00};
    vecs[4] = '{nb: 8'h07, io: 4'h0, exp_out: 2'b00};
    vecs[5] = '{nb: 8'h2F, io: 4'h5, exp_out: 2'b01};
    toggle_exp = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10};

    // reset state
    repeat (2) tick();
    check("rst_cfg_done", cfg_done, 0);
    check("rst_run_out", run_out, 0);
    check("rst_chain_out", {cfg_start_out, cfg_valid_out, cfg_data_out}, 0);
    rst = 1'b0;
    tick();

    // reset in the middle of a frame
    do_start();
    for (int i = FRAME - 1; i > FRAME - 1 - 50; i--) begin
      cfg_valid = 1'b1; cfg_data = frame_a[i];
      tick();
    end
    #2 rst = 1'b1;
    #1;
    check("midload_rst_done", cfg_done, 0);
    check("midload_rst_outs", {cfg_start_out, cfg_valid_out, cfg_data_out, run_out}, 0);
    cfg_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // a frame without cfg_start is ignored
    send_frame(frame_a, -1, pulses);
    tick();
    check("no_start_no_done", cfg_done, 0);
    check("no_start_no_fwd", pulses, 0);

    // full frame A followed by 5 forwarded bits
    do_start();
    send_frame(frame_a, -1, pulses);
    check("done_after_last_bit", cfg_done, 1);
    check("no_fwd_during_frame", pulses, 0);
    check("last_bit_not_fwd", cfg_valid_out, 0);
    extra = 5'b10110;
    pulses = 0;
    for (int i = 4; i >= 0; i--) begin
      cfg_valid = 1'b1; cfg_data = extra[i];
      tick();
      if (cfg_valid_out) pulses++;
      check("fwd_data", {cfg_valid_out, cfg_data_out}, {1'b1, extra[i]});
    end
    cfg_valid = 1'b0; cfg_data = 1'b0;
    tick();
    if (cfg_valid_out) pulses++;
    repeat (2) begin
      tick();
      if (cfg_valid_out) pulses++;
    end
    check("fwd_pulse_count", pulses, 5);
    check("done_stays_high", cfg_done, 1);

    // combinational AND4 vectors
    for (int v = 0; v < 6; v++) begin
      run_in_neighbours = vecs[v].nb;
      run_in_io = vecs[v].io;
      #1;
      check($sformatf("and4_vec%0d", v), run_out, vecs[v].exp_out);
    end

    // registered toggle via feedback
    run_in_neighbours = 8'h00;
    run = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("toggle_c%0d", c), run_out, toggle_exp[c]);
    end
    run = 1'b0;
    repeat (3) tick();
    check("toggle_hold", run_out, 2'b10);
    run_in_neighbours = 8'h0F;
    #1;
    check("comb_and_hold", run_out, 2'b11);

    // start with a coincident bit after configuration
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 1'b1;
    tick();
    cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = 1'b0;
    check("restart_done", cfg_done, 0);
    check("restart_run_out", run_out, 0);
    check("restart_not_fwd", cfg_valid_out, 0);
    check("restart_start_out", cfg_start_out, 1);
    run = 1'b1;
    tick();
    check("unconfigured_run_out", run_out, 0);
    run = 1'b0;

    // frame B with a stall mid-frame; discarded bit must not misalign it
    send_frame(frame_b, 60, pulses);
    check("frame_b_done", cfg_done, 1);
    check("frame_b_no_fwd", pulses, 0);
    for (int p = 0; p < 16; p++) begin
      run_in_io = 4'(p);
      run_in_neighbours = 8'(p * 17);
      #1;
      check($sformatf("oob_io_const_p%0d", p), run_out, 2'b10);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
